// File: rtl/credit_to_valrdy_if.sv
// credit_to_valrdy_if
//   Bundles both sides of the credit-to-valid/ready bridge.
//   Upstream (credit side):
//     data_in   - flit from the upstream sender
//     valid_in  - flit valid; the sender only raises it while holding a credit
//     yummy_in  - credit return pulse back to the sender
//   Downstream (valid/ready side):
//     data_out  - head-of-FIFO flit
//     valid_out - FIFO non-empty
//     ready_out - downstream can take the flit this cycle
//   Modports:
//     slave  - the bridge itself
//     master - the environment around it (sender plus downstream consumer)
interface credit_to_valrdy_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  yummy_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  ready_out;

  modport slave (
    input  data_in, valid_in, ready_out,
    output yummy_in, data_out, valid_out
  );

  modport master (
    output data_in, valid_in, ready_out,
    input  yummy_in, data_out, valid_out
  );
endinterface

// File: rtl/credit_to_valrdy.sv
// credit_to_valrdy
//   Receiving end of a credit-flow-controlled link. The local FIFO has one
//   entry per upstream credit, so every flit the sender has credit for is
//   absorbed. Each flit taken downstream returns one credit upstream as a
//   single-cycle yummy pulse, one cycle after the dequeue.
//   Ports:
//     clk    - single clock, rising edge
//     reset  - synchronous, active-high; clears pointers, count, storage
//     link   - credit_to_valrdy_if.slave (data_in/valid_in/yummy_in upstream,
//              data_out/valid_out/ready_out downstream)
//   Parameters:
//     DATA_WIDTH - flit width
//     DEPTH      - FIFO entries == credits held upstream after reset (>= 1)
module credit_to_valrdy #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input logic                clk,
  input logic                reset,
  credit_to_valrdy_if.slave  link
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  yummy_q;
  logic                  enq;
  logic                  deq;

  // Pointers wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A write while full is dropped even if a dequeue happens in the same
  // cycle; the credit protocol never allows it, and refusing it keeps the
  // contents and pointers intact.
  assign enq = link.valid_in && (count != CNT_W'(DEPTH));
  assign deq = link.valid_out && link.ready_out;

  assign link.valid_out = (count != '0);
  assign link.data_out  = mem[rd_ptr];
  assign link.yummy_in  = yummy_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the storage array is cleared on reset because data_out must
      // read 0 after reset; this costs a reset path on every flop.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      yummy_q <= 1'b0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= link.data_in;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // One credit per dequeue; back-to-back dequeues hold it high.
      yummy_q <= deq;
    end
  end

endmodule

// File: tb/tb_credit_to_valrdy.sv
// tb_credit_to_valrdy
//   Drives the bridge through the directed scenarios (packet, backpressure,
//   overflow, simultaneous enq/deq, pointer wrap, mid-operation reset) and
//   a randomized credit-respecting phase, comparing every cycle against a
//   queue-based model of the FIFO and its credit return.
module tb_credit_to_valrdy;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  credit_to_valrdy_if #(.DATA_WIDTH(DW)) link ();

  credit_to_valrdy #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .link  (link)
  );

  // Reference model state
  logic [DW-1:0] q [$];
  bit            yummy_exp = 1'b0;
  bit            head_zero = 1'b1;
  int            deq_total = 0;
  int            yummy_seen = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sender holds a credit if the slots it believes free are not exhausted.
  function automatic bit has_credit();
    return (q.size() + int'(yummy_exp)) < DEPTH;
  endfunction

  // One clock: drive inputs, update the model at the edge, check mid-cycle.
  task automatic step(input bit rst, input bit v, input logic [DW-1:0] d, input bit rdy);
    bit do_deq;
    bit do_enq;
    reset          = rst;
    link.valid_in  = v;
    link.data_in   = d;
    link.ready_out = rdy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      yummy_exp = 1'b0;
      head_zero = 1'b1;
    end else begin
      do_deq = (q.size() != 0) && rdy;
      do_enq = v && (q.size() < DEPTH);
      if (do_deq) begin
        void'(q.pop_front());
        deq_total++;
      end
      if (do_enq) begin
        q.push_back(d);
        head_zero = 1'b0;
      end
      yummy_exp = do_deq;
    end
    @(negedge clk);
    check("valid_out", 64'(link.valid_out), 64'(q.size() != 0));
    check("yummy_in", 64'(link.yummy_in), 64'(yummy_exp));
    check("count", 64'(dut.count), 64'(q.size()));
    if (q.size() != 0)  check("data_out", link.data_out, q[0]);
    else if (head_zero) check("data_out_reset", link.data_out, 64'h0);
    if (link.yummy_in) yummy_seen++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, rdy);
  endtask

  initial begin
    int y0;
    int sent;
    int guard;
    bit tog;
    bit r;
    bit v;

    reset = 1'b1;
    link.valid_in = 1'b0;
    link.data_in = '0;
    link.ready_out = 1'b0;

    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 64'hdead, 1'b1);
    check("reset_valid", 64'(link.valid_out), 64'h0);
    check("reset_data", link.data_out, 64'h0);

    // Three-flit packet with ready held high
    y0 = yummy_seen;
    step(1'b0, 1'b1, 64'h800000008084c008, 1'b1);
    step(1'b0, 1'b1, 64'h00fff10100000300, 1'b1);
    step(1'b0, 1'b1, 64'h0, 1'b1);
    idle(4, 1'b1);
    check("packet_yummies", 64'(yummy_seen - y0), 64'd3);

    // Backpressure: fill, then one dropped overflow write, then drain
    y0 = yummy_seen;
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, DW'(i), 1'b0);
    idle(2, 1'b0);
    step(1'b0, 1'b1, 64'd5, 1'b0);
    check("full_head", link.data_out, 64'd1);
    idle(6, 1'b1);
    check("overflow_yummies", 64'(yummy_seen - y0), 64'd4);

    // Simultaneous enqueue and dequeue at count=2
    step(1'b0, 1'b1, 64'd1, 1'b0);
    step(1'b0, 1'b1, 64'd2, 1'b0);
    step(1'b0, 1'b1, 64'd3, 1'b1);
    check("simul_count", 64'(dut.count), 64'd2);
    idle(4, 1'b1);

    // Ten flits with ready toggling every cycle, across pointer wrap
    y0 = yummy_seen;
    sent = 0;
    tog = 1'b0;
    guard = 0;
    while ((sent < 10) && (guard < 100)) begin
      v = has_credit();
      step(1'b0, v, DW'(sent + 1), tog);
      if (v) sent++;
      tog = ~tog;
      guard++;
    end
    check("toggle_sent", 64'(sent), 64'd10);
    idle(6, 1'b1);
    check("toggle_yummies", 64'(yummy_seen - y0), 64'd10);

    // Reset mid-operation: three buffered, one dequeued, then reset
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, DW'(16 + i), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 64'h77, 1'b1);
    check("midrst_valid", 64'(link.valid_out), 64'h0);
    check("midrst_yummy", 64'(link.yummy_in), 64'h0);
    check("midrst_data", link.data_out, 64'h0);
    step(1'b0, 1'b1, 64'ha5, 1'b0);
    check("post_reset_flit", link.data_out, 64'ha5);
    idle(3, 1'b1);

    // Randomized credit-respecting traffic with rare protocol violations
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) == 0);
      v = (has_credit() && ($urandom_range(0, 3) != 0)) || ($urandom_range(0, 29) == 0);
      step(r, v, {$urandom, $urandom}, $urandom_range(0, 2) != 0);
    end
    idle(6, 1'b1);
    check("yummy_total", 64'(yummy_seen), 64'(deq_total));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
